// File: rtl/uart_dump_pkg.sv
// rtl/uart_dump_pkg.sv - shared types and helpers for the capture-RAM UART dump sequencer
// Optional checksum trailer selected by UART_DUMP_CSUM_EN.
package uart_dump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_RD,
        ST_WAIT,
        ST_SEND,
`ifdef UART_DUMP_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } dump_state_t;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    // Bytes on the wire per frame: two header bytes, the data, and the optional checksum.
    function automatic int unsigned frame_len(input int unsigned depth);
`ifdef UART_DUMP_CSUM_EN
        return depth + 3;
`else
        return depth + 2;
`endif
    endfunction

endpackage

// File: rtl/uart_dump_sched.sv
// rtl/uart_dump_sched.sv - paces capture-RAM readout into a UART TX byte stream, one framed packet per start
// Checksum trailer byte present when UART_DUMP_CSUM_EN is defined.
module uart_dump_sched
    import uart_dump_pkg::*;
#(
    parameter int          ADDR_W = 9,
    parameter int          DEPTH  = 512,
    parameter logic [7:0]  HDR0   = HDR0_DEF,
    parameter logic [7:0]  HDR1   = HDR1_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [7:0]        ram_dout,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    dump_state_t state, state_nxt;
    logic        xfer;
    logic        last_byte;

    // Valid is decoded from registered state only, so it never follows tx_ready combinationally.
    always_comb begin
        tx_valid = (state == ST_HDR0) || (state == ST_HDR1) || (state == ST_SEND);
`ifdef UART_DUMP_CSUM_EN
        if (state == ST_CSUM) tx_valid = 1'b1;
`endif
    end

    assign xfer      = tx_valid & tx_ready;
    assign last_byte = (ram_addr == LAST_ADDR);
    assign ram_rd_en = (state == ST_RD);
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_HDR0;
                ST_HDR0: if (xfer)  state_nxt = ST_HDR1;
                ST_HDR1: if (xfer)  state_nxt = ST_RD;
                ST_RD:              state_nxt = ST_WAIT;
                ST_WAIT:            state_nxt = ST_SEND;
                ST_SEND: begin
                    if (xfer) begin
`ifdef UART_DUMP_CSUM_EN
                        state_nxt = last_byte ? ST_CSUM : ST_RD;
`else
                        state_nxt = last_byte ? ST_DONE : ST_RD;
`endif
                    end
                end
`ifdef UART_DUMP_CSUM_EN
                ST_CSUM: if (xfer)  state_nxt = ST_DONE;
`endif
                ST_DONE:            state_nxt = ST_IDLE;
                default:            state_nxt = ST_IDLE;
            endcase
        end
    end

`ifdef UART_DUMP_CSUM_EN
    logic [7:0] checksum;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            checksum <= 8'h00;
        end else if (!abort) begin
            if (state == ST_IDLE && start)     checksum <= 8'h00;
            else if (state == ST_SEND && xfer) checksum <= checksum + tx_data;
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ram_addr <= '0;
            tx_data  <= 8'h00;
        end else if (abort) begin
            ram_addr <= '0;
            tx_data  <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ram_addr <= '0;
                        tx_data  <= HDR0;
                    end
                end
                ST_HDR0: if (xfer) tx_data <= HDR1;
                ST_WAIT: tx_data <= ram_dout;
                ST_SEND: begin
                    // The last address is compared before incrementing, so a full-range DEPTH never wraps.
                    if (xfer) begin
                        if (last_byte) begin
`ifdef UART_DUMP_CSUM_EN
                            tx_data <= checksum + tx_data;
`endif
                        end else begin
                            ram_addr <= ram_addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (state_nxt == ST_DONE) ram_addr <= '0;
        end
    end

endmodule

// File: tb/tb_uart_dump_sched.sv
// tb/tb_uart_dump_sched.sv - scoreboard bench for uart_dump_sched (full-range 3-bit address, DEPTH=8)
module tb_uart_dump_sched;
    import uart_dump_pkg::*;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int FLEN   = int'(frame_len(DEPTH));

    logic              sys_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [7:0]        ram_dout = 8'h00;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              busy;
    logic              done;

    logic [7:0] mem [DEPTH];

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    int         rd_exp, rd_cnt, tx_cnt, done_cnt, max_addr;
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data;

    uart_dump_sched #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .abort     (abort),
        .ram_addr  (ram_addr),
        .ram_rd_en (ram_rd_en),
        .ram_dout  (ram_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) if (ram_rd_en) ram_dout <= mem[ram_addr];

    always @(negedge sys_rst_n) stall_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (stall_prev && sys_rst_n) begin
            n_cmp++;
            if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
                n_bad++;
                $display("FAIL hold: tx_valid=%b tx_data=%h required 1/%h", tx_valid, tx_data, stall_data);
            end
        end
        stall_prev = tx_valid && !tx_ready && !abort && sys_rst_n;
        stall_data = tx_data;
        if (ram_rd_en) begin
            n_cmp++;
            if (ram_addr !== rd_exp[ADDR_W-1:0]) begin
                n_bad++;
                $display("FAIL rd_addr: got %0d required %0d", ram_addr, rd_exp);
            end
            rd_exp++;
            rd_cnt++;
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        end
        if (tx_valid && tx_ready) begin
            logic [7:0] e;
            tx_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL tx_extra: got byte %h, none expected", tx_data);
            end else begin
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_bad++;
                    $display("FAIL tx_byte: got %h required %h", tx_data, e);
                end
            end
        end
        if (done) done_cnt++;
    end

    task automatic clear_sb();
        exp_q.delete();
        rd_exp   = 0;
        rd_cnt   = 0;
        tx_cnt   = 0;
        done_cnt = 0;
        max_addr = 0;
    endtask

    task automatic push_frame();
        logic [7:0] s;
        s = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(mem[i]);
            s = s + mem[i];
        end
`ifdef UART_DUMP_CSUM_EN
        exp_q.push_back(s);
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
    endtask

    task automatic run_to_done(input bit rnd, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge sys_clk); #1;
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        n_cmp += 6;
        if (ram_addr !== '0)    begin n_bad++; $display("FAIL rst_addr: got %h required 0", ram_addr); end
        if (ram_rd_en !== 1'b0) begin n_bad++; $display("FAIL rst_rd_en: got %b required 0", ram_rd_en); end
        if (tx_data !== 8'h00)  begin n_bad++; $display("FAIL rst_tx_data: got %h required 00", tx_data); end
        if (tx_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_tx_valid: got %b required 0", tx_valid); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (done !== 1'b0)      begin n_bad++; $display("FAIL rst_done: got %b required 0", done); end
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_frame(input bit rnd);
        bit ok;
        clear_sb();
        push_frame();
        tx_ready = 1'b1;
        pulse_start();
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            n_bad++;
            $display("FAIL start_latency: got valid=%b data=%h required 1/a5", tx_valid, tx_data);
        end
        run_to_done(rnd, ok);
        n_cmp += 2;
        if (!ok)           begin n_bad++; $display("FAIL done_timeout: got no done required done"); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL done_busy: got %b required 0", busy); end
        tx_ready = 1'b1;
        @(posedge sys_clk); #1;
        n_cmp += 6;
        if (done !== 1'b0)          begin n_bad++; $display("FAIL done_width: got %b required 0", done); end
        if (done_cnt !== 1)         begin n_bad++; $display("FAIL done_count: got %0d required 1", done_cnt); end
        if (exp_q.size() !== 0)     begin n_bad++; $display("FAIL frame_left: got %0d bytes pending required 0", exp_q.size()); end
        if (tx_cnt !== FLEN)        begin n_bad++; $display("FAIL frame_len: got %0d required %0d", tx_cnt, FLEN); end
        if (max_addr !== DEPTH - 1) begin n_bad++; $display("FAIL max_addr: got %0d required %0d", max_addr, DEPTH - 1); end
        if (rd_cnt !== DEPTH)       begin n_bad++; $display("FAIL rd_count: got %0d required %0d", rd_cnt, DEPTH); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'h30 + i * 3);
        clear_sb();
        push_frame();
        tx_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 100; c++) begin
            if (rd_cnt >= 2) break;
            @(posedge sys_clk); #1;
        end
        pulse_start();
        run_to_done(1'b0, ok);
        repeat (20) @(posedge sys_clk);
        #1;
        n_cmp += 4;
        if (!ok)            begin n_bad++; $display("FAIL restart_done: got no done required done"); end
        if (tx_cnt !== FLEN) begin n_bad++; $display("FAIL restart_len: got %0d required %0d", tx_cnt, FLEN); end
        if (done_cnt !== 1) begin n_bad++; $display("FAIL restart_done_cnt: got %0d required 1", done_cnt); end
        if (busy !== 1'b0)  begin n_bad++; $display("FAIL restart_busy: got %b required 0", busy); end
    endtask

    task automatic test_abort();
        bit ok;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(8'hC0 ^ i);
        clear_sb();
        push_frame();
        tx_ready = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (tx_valid && rd_cnt == 2) begin ok = 1'b1; break; end
            @(posedge sys_clk); #1;
        end
        abort = 1'b1;
        @(posedge sys_clk); #1;
        abort = 1'b0;
        n_cmp += 5;
        if (!ok)                       begin n_bad++; $display("FAIL abort_reach: got no SEND of byte 2 required it"); end
        if (tx_valid !== 1'b0)         begin n_bad++; $display("FAIL abort_valid: got %b required 0", tx_valid); end
        if (busy !== 1'b0)             begin n_bad++; $display("FAIL abort_busy: got %b required 0", busy); end
        if (ram_addr !== '0)           begin n_bad++; $display("FAIL abort_addr: got %0d required 0", ram_addr); end
        if (exp_q.size() !== FLEN - 4) begin n_bad++; $display("FAIL abort_sent: got %0d pending required %0d", exp_q.size(), FLEN - 4); end
        repeat (10) @(posedge sys_clk);
        #1;
        n_cmp += 2;
        if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses required 0", done_cnt); end
        if (tx_cnt !== 4)   begin n_bad++; $display("FAIL abort_count: got %0d bytes required 4", tx_cnt); end
        test_frame(1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        clear_sb();
        push_frame();
        tx_ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 100; c++) begin
            if (rd_cnt >= 3 && tx_valid) break;
            @(posedge sys_clk); #1;
        end
        #2;
        sys_rst_n = 1'b0;
        #1;
        n_cmp += 5;
        if (tx_valid !== 1'b0)  begin n_bad++; $display("FAIL arst_valid: got %b required 0", tx_valid); end
        if (tx_data !== 8'h00)  begin n_bad++; $display("FAIL arst_data: got %h required 00", tx_data); end
        if (ram_addr !== '0)    begin n_bad++; $display("FAIL arst_addr: got %0d required 0", ram_addr); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL arst_busy: got %b required 0", busy); end
        if (ram_rd_en !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_strobes: got rd_en=%b done=%b required 0/0", ram_rd_en, done);
        end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        exp_q.delete();
        @(posedge sys_clk); #1;
        test_frame(1'b1);
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 1);
        test_frame(1'b0);
        test_frame(1'b1);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
        test_frame(1'b1);
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        test_frame(1'b0);
        test_start_ignored();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
